// File: rtl/gcd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gcd_arbiter
// Brief    : Round-robin sequencer sharing one GCD engine among N_REQ clients.
// Revision : 1.0
// ============================================================================
module gcd_arbiter #(
  parameter int WIDTH   = 16,
  parameter int N_REQ   = 4,
  parameter int ID_W    = $clog2(N_REQ),
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_x,
  input  logic [N_REQ*WIDTH-1:0] req_y,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   eng_start,
  output logic [WIDTH-1:0]       eng_x,
  output logic [WIDTH-1:0]       eng_y,
  input  logic                   eng_done,
  input  logic [WIDTH-1:0]       eng_result,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_err,
  output logic                   busy
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state;
  logic [ID_W-1:0]  prio;
  logic [ID_W-1:0]  job_id;
  logic [CNT_W-1:0] wdog;
  logic             grant_vld;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  cand;
  logic [WIDTH-1:0] grant_x;
  logic [WIDTH-1:0] grant_y;

  // Scan downward in offset so the last hit is the closest at/after prio.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    grant_x   = '0;
    grant_y   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ID_W'((int'(prio) + i) % N_REQ);
      if (req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        grant_x = req_x[i*WIDTH +: WIDTH];
        grant_y = req_y[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && grant_vld) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign eng_start = (state == S_ISSUE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      prio       <= '0;
      job_id     <= '0;
      wdog       <= '0;
      eng_x      <= '0;
      eng_y      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            job_id <= grant_id;
            eng_x  <= grant_x;
            eng_y  <= grant_y;
            // A zero operand makes the answer the other operand; skip the engine.
            if (grant_x == '0 || grant_y == '0) begin
              state      <= S_RESP;
              rsp_valid  <= 1'b1;
              rsp_id     <= grant_id;
              rsp_result <= grant_x | grant_y;
              rsp_err    <= 1'b0;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          wdog  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_done) begin
            state      <= S_RESP;
            rsp_valid  <= 1'b1;
            rsp_id     <= job_id;
            rsp_result <= eng_result;
            rsp_err    <= 1'b0;
          end else if (wdog == CNT_LAST) begin
            state      <= S_RESP;
            rsp_valid  <= 1'b1;
            rsp_id     <= job_id;
            rsp_result <= '0;
            rsp_err    <= 1'b1;
          end else if (wdog != CNT_MAX) begin
            wdog <= wdog + 1'b1;
          end
        end
        S_RESP: begin
          prio  <= (job_id == ID_W'(N_REQ - 1)) ? '0 : job_id + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gcd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_arbiter
// Brief    : Scoreboard bench for gcd_arbiter with a behavioural engine model.
// Revision : 1.0
// ============================================================================
module tb_gcd_arbiter;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int T   = 8;

  typedef struct { int id; int res; bit err; int due; } exp_t;
  typedef struct { int x; int y; int lat; bit stray; int due; } job_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_x;
  logic [N*W-1:0] req_y;
  logic [N-1:0]   req_ready;
  logic           eng_start;
  logic [W-1:0]   eng_x;
  logic [W-1:0]   eng_y;
  logic           eng_done;
  logic [W-1:0]   eng_result;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_result;
  logic           rsp_err;
  logic           busy;

  gcd_arbiter #(.WIDTH(W), .N_REQ(N), .ID_W(IDW), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
    .eng_done(eng_done), .eng_result(eng_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t exp_q[$];
  job_t job_q[$];
  int   grant_log[$];

  logic [N-1:0] pend;
  logic [W-1:0] ox[N];
  logic [W-1:0] oy[N];
  int           refill[N];
  int           mprio;
  int           next_free;
  int           force_lat;
  bit           stray_en;
  bit           rst_drv;
  int           last_grant;

  function automatic void chk(string name, longint act, longint expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic int gcd(int a, int b);
    while (b != 0) begin
      int r;
      r = a % b;
      a = b;
      b = r;
    end
    return a;
  endfunction

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      if (pend[(mprio + k) % N]) return (mprio + k) % N;
    end
    return -1;
  endfunction

  // Reference model of one accepted job: result, error and response cycle.
  task automatic accept(int g);
    int   x, y, lat;
    bit   err;
    exp_t e;
    job_t j;
    x = int'(ox[g]);
    y = int'(oy[g]);
    if (x == 0 || y == 0) begin
      e = '{id: g, res: x | y, err: 1'b0, due: cyc + 1};
      exp_q.push_back(e);
    end else begin
      lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, T + 1));
      err = (lat >= T);
      e = '{id: g, res: err ? 0 : gcd(x, y), err: err, due: err ? cyc + 2 + T : cyc + 3 + lat};
      exp_q.push_back(e);
      j = '{x: x, y: y, lat: lat, stray: stray_en || ($urandom_range(0, 3) == 0), due: cyc + 1};
      job_q.push_back(j);
    end
    next_free  = e.due + 1;
    last_grant = cyc;
    pend[g]    = 1'b0;
    mprio      = (g + 1) % N;
    grant_log.push_back(g);
    if (refill[g] > 0) begin
      refill[g]--;
      ox[g]   = W'($urandom_range(1, 255));
      oy[g]   = W'($urandom_range(1, 255));
      pend[g] = 1'b1;
    end
  endtask

  task automatic tick();
    int g;
    @(posedge clk);
    #1;
    reset     = rst_drv;
    req_valid = pend;
    for (int i = 0; i < N; i++) begin
      req_x[i*W +: W] = ox[i];
      req_y[i*W +: W] = oy[i];
    end
    @(negedge clk);
    chk("busy", busy, cyc < next_free);
    if (pend != '0 && cyc >= next_free) begin
      g = pick();
      chk("req_ready_grant", req_ready, 1 << g);
      if (int'(req_ready) == (1 << g)) accept(g);
    end else begin
      chk("req_ready_quiet", req_ready, 0);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((pend != '0 || cyc <= next_free) && n < 400);
    if (pend != '0 || cyc <= next_free) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_wait: still busy after %0d cycles", n);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_x", eng_x, 0);
    chk("rst_eng_y", eng_y, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic do_reset();
    rst_drv = 1'b1;
    tick();
    next_free = cyc + 1;
    exp_q.delete();
    job_q.delete();
    pend    = '0;
    mprio   = 0;
    rst_drv = 1'b0;
    tick();
    check_reset_vals();
  endtask

  task automatic request(int i, int x, int y, int lat);
    force_lat = lat;
    ox[i]     = W'(x);
    oy[i]     = W'(y);
    pend[i]   = 1'b1;
  endtask

  // Engine model: computes the GCD and answers after the scheduled latency.
  initial begin
    int           cd;
    bit           act;
    logic [W-1:0] res;
    job_t         j;
    act        = 1'b0;
    cd         = 0;
    res        = '0;
    eng_done   = 1'b0;
    eng_result = '0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (act) begin
        if (cd == 0) begin
          eng_done   = 1'b1;
          eng_result = res;
          act        = 1'b0;
        end else begin
          cd--;
        end
      end
      if (eng_start === 1'b1) begin
        if (job_q.size() == 0) begin
          chk("unexpected_start", eng_start, 0);
        end else begin
          j = job_q.pop_front();
          chk("start_cycle", cyc, j.due);
          chk("eng_x", eng_x, j.x);
          chk("eng_y", eng_y, j.y);
          res = W'(gcd(int'(eng_x), int'(eng_y)));
          cd  = j.lat;
          act = 1'b1;
          if (j.stray && !eng_done) begin
            eng_done   = 1'b1;
            eng_result = res ^ 8'h5a;
          end
        end
      end
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT answers.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", rsp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_cycle", cyc, e.due);
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_err", rsp_err, e.err);
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        chk("rsp_missing", rsp_valid, 1);
        exp_q.delete(0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int rr_exp[6];
    int n;
    rr_exp = '{0, 1, 2, 3, 0, 2};
    reset = 1'b1; req_valid = '0; req_x = '0; req_y = '0;
    pend = '0; mprio = 0; next_free = 0; force_lat = -1; stray_en = 1'b0;
    rst_drv = 1'b1; last_grant = 0;
    for (int i = 0; i < N; i++) begin
      ox[i] = '0; oy[i] = '0; refill[i] = 0;
    end
    repeat (3) tick();
    check_reset_vals();
    rst_drv = 1'b0;

    request(2, 12, 15, 5);
    wait_idle();

    request(0, 0, 9, -1);
    wait_idle();
    request(0, 0, 0, -1);
    wait_idle();

    do_reset();
    grant_log.delete();
    refill[0] = 1; refill[2] = 1;
    for (int i = 0; i < N; i++) request(i, $urandom_range(1, 255), $urandom_range(1, 255), 2);
    wait_idle();
    chk("rr_count", grant_log.size(), 6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++) chk("rr_order", grant_log[k], rr_exp[k]);

    request(1, 20, 30, T + 1);
    wait_idle();
    request(1, 45, 27, T);
    wait_idle();
    request(2, 21, 14, -1);
    wait_idle();
    request(3, 9, 6, T - 1);
    wait_idle();

    request(3, 25, 35, T + 1);
    n = 0;
    while ((pend != '0 || cyc < last_grant + 4) && n < 50) begin
      tick();
      n++;
    end
    do_reset();
    repeat (12) tick();
    stray_en = 1'b1;
    request(0, 8, 12, 3);
    wait_idle();
    stray_en = 1'b0;

    force_lat = -1;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          ox[i]   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
          oy[i]   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
          pend[i] = 1'b1;
        end
      end
      repeat ($urandom_range(1, 6)) tick();
    end
    wait_idle();
    repeat (T + 4) tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
